// File: rtl/yrv_uart_boot_ctrl.sv
// UART boot loader: receives a program image over 8N1 serial, writes it
// to program memory word by word, then releases the CPU from reset.
module yrv_uart_boot_ctrl #(
  parameter int CLK_FREQUENCY  = 50_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              aux_uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              cpu_resetb,
  output logic              boot_busy,
  output logic              boot_error
);

  localparam int BIT_CYC = CLK_FREQUENCY / BAUD_RATE;
  localparam int BW = $clog2(BIT_CYC + 1);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CYC - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BIT_CYC / 2 - 1);
  localparam logic [IW-1:0] TO_CNT    = IW'(TIMEOUT_CYCLES);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_t;

  typedef enum logic [1:0] {
    LOAD, FLUSH, DRAIN, DONE
  } st_t;

  rx_t         rx_st;
  st_t         st;
  logic        rx_s1;
  logic        rx_s2;
  logic [BW-1:0] cyc_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  sh;
  logic        byte_vld;
  logic        start_det;
  logic        frame_err;
  logic [IW-1:0] idle;
  logic [1:0]  byte_cnt;
  logic [23:0] acc;
  logic        wr_acc;
  logic        wr_last;

  assign wr_acc  = mem_we && mem_ready;
  assign wr_last = wr_acc && (mem_addr == ADDR_LAST);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_st     <= RX_IDLE;
      cyc_cnt   <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      byte_vld  <= 1'b0;
      start_det <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1     <= aux_uart_rx;
      rx_s2     <= rx_s1;
      byte_vld  <= 1'b0;
      start_det <= 1'b0;
      frame_err <= 1'b0;
      unique case (rx_st)
        RX_IDLE: begin
          if (!rx_s2) begin
            rx_st     <= RX_START;
            cyc_cnt   <= '0;
            start_det <= 1'b1;
          end
        end
        RX_START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            bit_idx <= '0;
            rx_st   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            sh      <= {rx_s2, sh[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_st <= RX_STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            if (rx_s2) begin
              byte_vld <= 1'b1;
              rx_st    <= RX_IDLE;
            end else begin
              frame_err <= 1'b1;
              rx_st     <= RX_WAIT;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (rx_s2) rx_st <= RX_IDLE;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      st         <= LOAD;
      idle       <= '0;
      byte_cnt   <= '0;
      acc        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_resetb <= 1'b0;
      boot_busy  <= 1'b1;
      boot_error <= 1'b0;
    end else begin
      if (st == LOAD && (byte_vld || start_det))
        idle <= '0;
      else if (st == LOAD && idle != TO_CNT)
        idle <= idle + 1'b1;

      if (wr_acc) begin
        mem_we   <= 1'b0;
        mem_addr <= mem_addr + 1'b1;
      end

      if (frame_err && st == LOAD) boot_error <= 1'b1;

      unique case (st)
        LOAD: begin
          if (wr_last) begin
            st <= DRAIN;
          end else if (byte_vld) begin
            if (byte_cnt == 2'd3) begin
              acc      <= '0;
              byte_cnt <= '0;
              // A full word behind a stalled write is dropped, not queued
              if (mem_we) begin
                boot_error <= 1'b1;
              end else begin
                mem_wdata <= {sh, acc};
                mem_we    <= 1'b1;
              end
            end else begin
              unique case (byte_cnt)
                2'd0:    acc[7:0]   <= sh;
                2'd1:    acc[15:8]  <= sh;
                default: acc[23:16] <= sh;
              endcase
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (idle == TO_CNT) begin
            st <= FLUSH;
          end
        end
        FLUSH: begin
          if (wr_last || byte_cnt == 2'd0) begin
            st <= DRAIN;
          end else if (!mem_we) begin
            mem_wdata <= {8'h00, acc};
            mem_we    <= 1'b1;
            acc       <= '0;
            byte_cnt  <= '0;
            st        <= DRAIN;
          end
        end
        DRAIN: begin
          if (!mem_we) begin
            st         <= DONE;
            cpu_resetb <= 1'b1;
            boot_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_yrv_uart_boot_ctrl.sv
// Directed bench for yrv_uart_boot_ctrl with a write scoreboard.
// Small clock/baud ratio and timeout keep the run short.
module tb_yrv_uart_boot_ctrl;

  localparam int T   = 2000;
  localparam int BIT = 10;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          rx = 1'b1;
  logic          mem_ready = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_resetb;
  logic          boot_busy;
  logic          boot_error;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int unstable = 0;
  logic [AW+31:0] exp_q[$];

  logic          pw = 1'b0;
  logic          pacc = 1'b0;
  logic [AW-1:0] pa = '0;
  logic [31:0]   pd = '0;

  yrv_uart_boot_ctrl #(
    .CLK_FREQUENCY (1_000_000),
    .BAUD_RATE     (100_000),
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .aux_uart_rx(rx),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .cpu_resetb (cpu_resetb),
    .boot_busy  (boot_busy),
    .boot_error (boot_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory side: each accepted write is checked against the scoreboard
  always @(negedge clk) begin
    logic [AW+31:0] e;
    if (resetb && pw && !pacc && mem_we &&
        (mem_addr !== pa || mem_wdata !== pd))
      unstable++;
    pw   = mem_we;
    pa   = mem_addr;
    pd   = mem_wdata;
    pacc = mem_we && mem_ready;
    if (resetb && mem_we && mem_ready) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL wr_unexp got addr=%0d data=%h want none",
               mem_addr, mem_wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        assert ({mem_addr, mem_wdata} === e) else begin
          bad++;
          $error("FAIL wr got addr=%0d data=%h want addr=%0d data=%h",
                 mem_addr, mem_wdata, e[AW+31:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(logic b);
    rx = b;
    tick(BIT);
  endtask

  task automatic send_byte(logic [7:0] b, logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    rx = 1'b1;
    tick(2);
  endtask

  task automatic push(int a, logic [31:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  task automatic do_reset();
    rx = 1'b1;
    mem_ready = 1'b1;
    resetb = 1'b0;
    tick(3);
    chk("rst_we", 64'(mem_we), 0);
    chk("rst_addr", 64'(mem_addr), 0);
    chk("rst_wdata", 64'(mem_wdata), 0);
    chk("rst_cpu", 64'(cpu_resetb), 0);
    chk("rst_busy", 64'(boot_busy), 1);
    chk("rst_err", 64'(boot_error), 0);
    resetb = 1'b1;
    tick(1);
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (boot_busy !== 1'b0 && n < budget) begin
      tick(1);
      n++;
    end
    chk("done_to", 64'(boot_busy), 0);
    chk("done_cpu", 64'(cpu_resetb), 1);
  endtask

  initial begin
    int t_end;
    int n;
    logic [31:0] w;

    // One word, then idle until timeout
    do_reset();
    push(0, 32'h12345678);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'h34);
    send_byte(8'h12);
    t_end = cyc;
    n = 0;
    while (cpu_resetb !== 1'b1 && n < T + 200) begin
      tick(1);
      n++;
    end
    total++;
    assert (cyc - t_end >= T - 10 && cyc - t_end <= T + 5) else begin
      bad++;
      $error("FAIL rise_time got=%0d want=%0d..%0d",
             cyc - t_end, T - 10, T + 5);
    end
    chk("t1_busy", 64'(boot_busy), 0);
    chk("t1_err", 64'(boot_error), 0);
    chk("t1_q", 64'(exp_q.size()), 0);

    // Full word plus a zero-padded partial word on timeout
    do_reset();
    push(0, 32'hDDCCBBAA);
    push(1, 32'h0000FFEE);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    send_byte(8'hEE);
    send_byte(8'hFF);
    wait_done(T + 200);
    chk("t2_q", 64'(exp_q.size()), 0);
    chk("t2_err", 64'(boot_error), 0);

    // Stalled memory: second word is an overrun
    do_reset();
    mem_ready = 1'b0;
    push(0, 32'h04030201);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    tick(700);
    chk("t3_we", 64'(mem_we), 1);
    chk("t3_addr", 64'(mem_addr), 0);
    chk("t3_data", 64'(mem_wdata), 64'h04030201);
    chk("t3_err", 64'(boot_error), 1);
    chk("t3_stable", 64'(unstable), 0);
    mem_ready = 1'b1;
    wait_done(T + 500);
    chk("t3_q", 64'(exp_q.size()), 0);

    // Framing error, then a good word still lands at address 0
    do_reset();
    send_byte(8'h55, 1'b0);
    chk("t4_err", 64'(boot_error), 1);
    push(0, 32'hA1B2C3D4);
    send_byte(8'hD4);
    send_byte(8'hC3);
    send_byte(8'hB2);
    send_byte(8'hA1);
    wait_done(T + 200);
    chk("t4_q", 64'(exp_q.size()), 0);
    chk("t4_err2", 64'(boot_error), 1);

    // Memory fills: four writes, trailing bytes ignored
    do_reset();
    for (int k = 0; k < 4; k++) begin
      w = {8'(4 * k + 4), 8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1)};
      push(k, w);
    end
    for (int i = 1; i <= 20; i++) send_byte(8'(i));
    chk("t5_busy", 64'(boot_busy), 0);
    chk("t5_cpu", 64'(cpu_resetb), 1);
    chk("t5_we", 64'(mem_we), 0);
    chk("t5_err", 64'(boot_error), 0);
    chk("t5_q", 64'(exp_q.size()), 0);

    // Reset mid-byte during the second word, then a fresh image
    do_reset();
    push(0, 32'h44332211);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("t6_q0", 64'(exp_q.size()), 0);
    do_reset();
    push(0, 32'hCAFEF00D);
    send_byte(8'h0D);
    send_byte(8'hF0);
    send_byte(8'hFE);
    send_byte(8'hCA);
    wait_done(T + 200);
    chk("t6_q", 64'(exp_q.size()), 0);

    // No bytes at all: boot straight into the existing image
    do_reset();
    wait_done(T + 100);
    chk("t7_q", 64'(exp_q.size()), 0);
    chk("t7_addr", 64'(mem_addr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
